// File: rtl/logic_op_scheduler.sv
// Two-requester logic-op unit: round-robin grant, one-cycle execute, result held until consumed.
// Throughput is one command per three cycles; per-requester completion counters saturate.
module logic_op_scheduler #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    output logic [7:0]       done_cnt0,
    output logic [7:0]       done_cnt1
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_id;
    logic             r_last;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_id;
    logic [7:0]       r_cnt0;
    logic [7:0]       r_cnt1;

    logic             w_idle;
    logic             w_grant0;
    logic             w_grant1;
    logic             w_accept;
    logic             w_xfer;
    logic [WIDTH-1:0] w_result;

    // r_last holds the previous winner; on a tie the other requester goes next.
    assign w_idle   = (r_state == StIdle);
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || r_last);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid || !r_last);
    assign w_accept = w_grant0 || w_grant1;
    assign w_xfer   = (r_state == StDone) && out_ready;

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign out_valid  = (r_state == StDone);
    assign out_data   = r_out_data;
    assign out_id     = r_out_id;
    assign done_cnt0  = r_cnt0;
    assign done_cnt1  = r_cnt1;

    always_comb begin
        w_result = '0;
        case (r_op)
            3'b000:  w_result = r_a & r_b;
            3'b001:  w_result = r_a | r_b;
            3'b010:  w_result = ~r_a;
            3'b011:  w_result = r_a ^ r_b;
            3'b100:  w_result = ~(r_a & r_b);
            3'b101:  w_result = ~(r_a | r_b);
            3'b110:  w_result = ~(r_a ^ r_b);
            3'b111:  w_result = ~r_a + WIDTH'(1);
            default: w_result = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_accept) w_state_next = StExec;
            StExec:  w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_id   <= 1'b0;
            r_last <= 1'b1;
        end else if (w_accept) begin
            r_a    <= w_grant1 ? req1_a : req0_a;
            r_b    <= w_grant1 ? req1_b : req0_b;
            r_op   <= w_grant1 ? req1_op : req0_op;
            r_id   <= w_grant1;
            r_last <= w_grant1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data <= '0;
            r_out_id   <= 1'b0;
        end else if (r_state == StExec) begin
            r_out_data <= w_result;
            r_out_id   <= r_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt0 <= 8'd0;
            r_cnt1 <= 8'd0;
        end else if (w_xfer) begin
            if (!r_out_id && (r_cnt0 != 8'hFF)) r_cnt0 <= r_cnt0 + 8'd1;
            if (r_out_id && (r_cnt1 != 8'hFF))  r_cnt1 <= r_cnt1 + 8'd1;
        end
    end

endmodule

// File: tb/tb_logic_op_scheduler.sv
// Bench for logic_op_scheduler: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_logic_op_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic        out_valid, out_id;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [7:0]  done_cnt0, done_cnt1;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    logic_op_scheduler #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .done_cnt0  (done_cnt0),
        .done_cnt1  (done_cnt1)
    );

    function automatic logic [15:0] ref_op(input logic [2:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return a ^ b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~(a ^ b);
            default: return 16'(17'h10000 - {1'b0, a});
        endcase
    endfunction

    task automatic clear_inputs;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready  = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Drives one command, waits for its result (out_ready held 1) and returns it.
    task automatic issue(input bit id, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, output logic [15:0] d, output logic oid,
                         output bit ok);
        ok  = 1'b0;
        d   = '0;
        oid = 1'b0;
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            clear_inputs();
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) begin
                d   = out_data;
                oid = out_id;
                ok  = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    task automatic test_reset;
        #3;
        n_checks += 5;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        if (out_data !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0000", out_data); end
        if (out_id !== 1'b0) begin n_bad++; $display("FAIL reset_id: got %b want 0", out_id); end
        if (done_cnt0 !== 8'd0) begin n_bad++; $display("FAIL reset_cnt0: got %0d want 0", done_cnt0); end
        if (done_cnt1 !== 8'd0) begin n_bad++; $display("FAIL reset_cnt1: got %0d want 0", done_cnt1); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single;
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h1234; req0_op = 3'b111;
        out_ready = 1'b1;
        #1;
        n_checks += 2;
        if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL single_rdy0: got %b want 1", req0_ready); end
        if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL single_rdy1: got %b want 0", req1_ready); end
        @(negedge clk);
        #1;
        n_checks += 2;
        if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL single_rdy0_exec: got %b want 0", req0_ready); end
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_exec: got %b want 0", out_valid); end
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
        if (out_data !== 16'h0001) begin n_bad++; $display("FAIL single_data: got %h want 0001", out_data); end
        if (out_id !== 1'b0) begin n_bad++; $display("FAIL single_id: got %b want 0", out_id); end
        @(negedge clk);
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_after: got %b want 0", out_valid); end
        if (done_cnt0 !== 8'd1) begin n_bad++; $display("FAIL single_cnt0: got %0d want 1", done_cnt0); end
    endtask

    task automatic test_tie;
        logic [15:0] got_d[4];
        logic        got_i[4];
        logic [15:0] exp_d[4];
        logic        exp_i[4];
        int          n = 0;
        exp_d = '{16'hF000, 16'h0FF0, 16'hF000, 16'h0FF0};
        exp_i = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'hF0F0; req0_b = 16'hFF00; req0_op = 3'b000;
        req1_valid = 1'b1; req1_a = 16'hF0F0; req1_b = 16'hFF00; req1_op = 3'b011;
        out_ready = 1'b1;
        #1;
        n_checks += 2;
        if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL tie_first_rdy0: got %b want 1", req0_ready); end
        if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL tie_first_rdy1: got %b want 0", req1_ready); end
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got_d[n] = out_data;
                got_i[n] = out_id;
                n++;
            end
        end
        clear_inputs();
        n_checks++;
        if (n != 4) begin n_bad++; $display("FAIL tie_count: got %0d want 4", n); end
        for (int k = 0; k < n; k++) begin
            n_checks += 2;
            if (got_d[k] !== exp_d[k]) begin n_bad++; $display("FAIL tie_data%0d: got %h want %h", k, got_d[k], exp_d[k]); end
            if (got_i[k] !== exp_i[k]) begin n_bad++; $display("FAIL tie_id%0d: got %b want %b", k, got_i[k], exp_i[k]); end
        end
    endtask

    task automatic test_hold;
        do_reset();
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 16'h1234; req1_b = 16'h00F0; req1_op = 3'b001;
        out_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            n_checks += 5;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid%0d: got %b want 1", c, out_valid); end
            if (out_data !== 16'h12F4) begin n_bad++; $display("FAIL hold_data%0d: got %h want 12f4", c, out_data); end
            if (out_id !== 1'b1) begin n_bad++; $display("FAIL hold_id%0d: got %b want 1", c, out_id); end
            if (req0_ready !== 1'b0) begin n_bad++; $display("FAIL hold_rdy0_%0d: got %b want 0", c, req0_ready); end
            if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL hold_rdy1_%0d: got %b want 0", c, req1_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        clear_inputs();
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release: got %b want 0", out_valid); end
        if (done_cnt1 !== 8'd1) begin n_bad++; $display("FAIL hold_cnt1: got %0d want 1", done_cnt1); end
    endtask

    task automatic test_opcodes;
        logic [15:0] exp_tab[8];
        logic [15:0] d;
        logic        oid;
        bit          ok;
        exp_tab = '{16'h2495, 16'hFFFF, 16'hDB6A, 16'hDB6A, 16'hDB6A, 16'h0000, 16'h2495, 16'hDB6B};
        do_reset();
        for (int op = 0; op < 8; op++) begin
            issue(1'b0, 16'h2495, 16'hFFFF, 3'(op), d, oid, ok);
            n_checks += 3;
            if (!ok) begin n_bad++; $display("FAIL op%0d_timeout: got no result want result", op); end
            if (d !== exp_tab[op]) begin n_bad++; $display("FAIL op%0d_data: got %h want %h", op, d, exp_tab[op]); end
            if (oid !== 1'b0) begin n_bad++; $display("FAIL op%0d_id: got %b want 0", op, oid); end
        end
    endtask

    // Runs right after test_opcodes, so done_cnt0 starts at 8.
    task automatic test_reset_in_done;
        logic [15:0] d;
        logic        oid;
        bit          ok;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'h00FF; req0_b = 16'h0F0F; req0_op = 3'b000;
        out_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rdone_pre_valid: got %b want 1", out_valid); end
        if (done_cnt0 !== 8'd8) begin n_bad++; $display("FAIL rdone_pre_cnt0: got %0d want 8", done_cnt0); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rdone_async_valid: got %b want 0", out_valid); end
        if (out_data !== 16'h0) begin n_bad++; $display("FAIL rdone_data: got %h want 0000", out_data); end
        if (done_cnt0 !== 8'd0) begin n_bad++; $display("FAIL rdone_cnt0: got %0d want 0", done_cnt0); end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_checks += 2;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rdone_held_valid: got %b want 0", out_valid); end
        if (done_cnt0 !== 8'd0) begin n_bad++; $display("FAIL rdone_held_cnt0: got %0d want 0", done_cnt0); end
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 16'h00FF, 16'h0F0F, 3'b001, d, oid, ok);
        @(negedge clk);
        n_checks += 3;
        if (!ok) begin n_bad++; $display("FAIL rdone_next_timeout: got no result want result"); end
        if (d !== 16'h0FFF) begin n_bad++; $display("FAIL rdone_next_data: got %h want 0fff", d); end
        if (done_cnt0 !== 8'd1) begin n_bad++; $display("FAIL rdone_next_cnt0: got %0d want 1", done_cnt0); end
    endtask

    task automatic test_saturate;
        int  n_res = 0;
        bit  wrapped = 1'b0;
        logic [7:0] prev = 8'd0;
        do_reset();
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 16'h5A5A; req1_b = 16'h0F0F; req1_op = 3'b011;
        out_ready = 1'b1;
        for (int c = 0; c < 960 && n_res < 300; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) n_res++;
            if (done_cnt1 < prev) wrapped = 1'b1;
            prev = done_cnt1;
            req1_a = 16'($urandom);
        end
        req1_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks += 4;
        if (n_res != 300) begin n_bad++; $display("FAIL sat_results: got %0d want 300", n_res); end
        if (wrapped) begin n_bad++; $display("FAIL sat_wrap: got wrap want none"); end
        if (done_cnt1 !== 8'd255) begin n_bad++; $display("FAIL sat_cnt1: got %0d want 255", done_cnt1); end
        if (done_cnt0 !== 8'd0) begin n_bad++; $display("FAIL sat_cnt0: got %0d want 0", done_cnt0); end
    endtask

    // Model tracks only "command pending", "result held", last winner and counts.
    task automatic test_random;
        bit          m_pend = 1'b0, m_has = 1'b0, m_last = 1'b1, m_pid = 1'b0, m_id = 1'b0;
        logic [15:0] m_pa = '0, m_pb = '0, m_res = '0;
        logic [2:0]  m_pop = '0;
        int          c0 = 0, c1 = 0;
        bit          v0, v1, ordy, g0, g1, idle;
        logic [15:0] a0, b0, a1, b1;
        logic [2:0]  o0, o1;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_checks += 3;
            if (out_valid !== m_has) begin n_bad++; $display("FAIL rnd_valid@%0d: got %b want %b", c, out_valid, m_has); end
            if (done_cnt0 !== 8'(c0)) begin n_bad++; $display("FAIL rnd_cnt0@%0d: got %0d want %0d", c, done_cnt0, c0); end
            if (done_cnt1 !== 8'(c1)) begin n_bad++; $display("FAIL rnd_cnt1@%0d: got %0d want %0d", c, done_cnt1, c1); end
            if (m_has) begin
                n_checks += 2;
                if (out_data !== m_res) begin n_bad++; $display("FAIL rnd_data@%0d: got %h want %h", c, out_data, m_res); end
                if (out_id !== m_id) begin n_bad++; $display("FAIL rnd_id@%0d: got %b want %b", c, out_id, m_id); end
            end
            v0 = ($urandom_range(0, 2) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            a0 = 16'($urandom); b0 = 16'($urandom); o0 = 3'($urandom);
            a1 = 16'($urandom); b1 = 16'($urandom); o1 = 3'($urandom);
            req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
            req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
            out_ready = ordy;
            idle = !m_pend && !m_has;
            g0 = idle && v0 && (!v1 || m_last);
            g1 = idle && v1 && (!v0 || !m_last);
            #1;
            n_checks += 2;
            if (req0_ready !== g0) begin n_bad++; $display("FAIL rnd_rdy0@%0d: got %b want %b", c, req0_ready, g0); end
            if (req1_ready !== g1) begin n_bad++; $display("FAIL rnd_rdy1@%0d: got %b want %b", c, req1_ready, g1); end
            @(posedge clk);
            if (m_has) begin
                if (ordy) begin
                    if (m_id) begin if (c1 < 255) c1++; end
                    else begin if (c0 < 255) c0++; end
                    m_has = 1'b0;
                end
            end else if (m_pend) begin
                m_res  = ref_op(m_pop, m_pa, m_pb);
                m_id   = m_pid;
                m_has  = 1'b1;
                m_pend = 1'b0;
            end else if (g0 || g1) begin
                m_pa   = g1 ? a1 : a0;
                m_pb   = g1 ? b1 : b0;
                m_pop  = g1 ? o1 : o0;
                m_pid  = g1;
                m_last = g1;
                m_pend = 1'b1;
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_hold();
        test_opcodes();
        test_reset_in_done();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/logic_op_scheduler.md
LOGIC_OP_SCHEDULER -- requirements
Module: logic_op_scheduler

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 req0_valid  input  1  requester 0 holds a command.
REQ-005 req0_ready  output  1  requester 0 command accepted this cycle when high with req0_valid.
REQ-006 req0_a, req0_b  input  WIDTH each  requester 0 operands.
REQ-007 req0_op  input  3  requester 0 opcode.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  same widths and meanings as REQ-004..007, for requester 1.
REQ-009 out_valid  output  1  result register holds an unconsumed result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out_data  output  WIDTH  result value.
REQ-012 out_id  output  1  index of the requester that issued the result.
REQ-013 done_cnt0, done_cnt1  output  8 each  completed-result counts per requester, saturating.

Function
REQ-014 Opcodes: 000 A&B; 001 A|B; 010 ~A; 011 A^B; 100 ~(A&B); 101 ~(A|B); 110 ~(A^B); 111 (~A)+1 mod 2^WIDTH. B is ignored for 010 and 111.
REQ-015 FSM states: IDLE, EXEC, DONE. Encoding is free.
REQ-016 IDLE: the block grants at most one requester. On grant, it latches A, B, op and id into operand registers, and moves to EXEC on the next edge.
REQ-017 EXEC: the block computes the REQ-014 function from the operand registers, loads out_data and out_id, and moves to DONE. This state lasts exactly one cycle.
REQ-018 DONE: out_valid=1. If out_ready=1, the transfer completes at the edge, and the FSM returns to IDLE. Otherwise the FSM stays in DONE.
REQ-019 out_valid is high only in DONE.
REQ-020 out_data and out_id are stable while out_valid=1 and out_ready=0.
REQ-021 reqN_ready is high only in IDLE, and only for the granted requester. At most one ready is high per cycle.
REQ-022 reqN_ready does not depend combinationally on out_ready.
REQ-023 Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last is granted (round-robin).
  - The last-grant pointer updates only on an actual accept.
REQ-024 Latency: accept at edge N, then out_valid=1 from edge N+1 to the transfer edge. The next accept is possible no earlier than one cycle after the transfer edge. Maximum throughput is one command per 3 cycles.
REQ-025 done_cntN increments by 1 on each completed output transfer with out_id=N. It saturates at 255 and does not wrap.
REQ-026 A requester dropping valid before it is granted causes no action. Commands are never lost once accepted.
REQ-027 Requester inputs are sampled only on the accept edge. Changes at other times have no effect.

Reset
REQ-028 While rst_n=0, the following hold, independent of clk:
  - state=IDLE
  - out_valid=0
  - out_data=0, out_id=0
  - operand registers=0
  - done_cnt0=done_cnt1=0
  - last-grant pointer=1, so requester 0 wins the first tie
REQ-029 Reset asserted in EXEC or DONE discards the in-flight command. No output transfer or counter increment occurs for it.
REQ-030 After rst_n rises, the first grant is possible on the first rising edge.

Verification
REQ-031 Only req0 valid, A=FFFF, op=111, out_ready=1 -> req0_ready high for 1 cycle; out_valid one cycle later with out_data=0001, out_id=0; done_cnt0=1.
REQ-032 Both valid from reset; req0 A=F0F0 B=FF00 op=000; req1 A=F0F0 B=FF00 op=011 -> first result F000 id 0, second result 0FF0 id 1; grants alternate on further ties.
REQ-033 Command accepted, out_ready held 0 for 5 cycles -> out_valid, out_data and out_id stay constant; no reqN_ready during the hold; transfer on the first out_ready=1 cycle.
REQ-034 All 8 opcodes with A=2495, B=FFFF -> 2495, FFFF, DB6A, DB6A, DB6A, 0000, 2495, DB6B.
REQ-035 rst_n pulsed low while in DONE -> out_valid drops immediately (asynchronously); counters return to 0; the next command completes normally.
REQ-036 300 back-to-back req1 commands with out_ready=1 -> done_cnt1=255 (saturated); done_cnt0=0.
